// File: rtl/ej32_store_seq_if.sv
// Request/bus bundle for the eJ32 byte-serial store sequencer.
// The sequencer takes the slave view; the control FSM and memory arbiter side take the master view.
interface ej32_store_seq_if #(
  parameter int DSZ = 32,
  parameter int ASZ = 17
);
  logic           st_req;
  logic           st_rdy;
  logic [1:0]     st_wsz;
  logic [ASZ-1:0] st_a;
  logic [DSZ-1:0] st_d;
  logic           st_done;
  logic           st_err;
  logic           mem_we;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_d;
  logic           mem_gnt;

  modport slave (
    input  st_req, st_wsz, st_a, st_d, mem_gnt,
    output st_rdy, st_done, st_err, mem_we, mem_a, mem_d
  );

  modport master (
    output st_req, st_wsz, st_a, st_d, mem_gnt,
    input  st_rdy, st_done, st_err, mem_we, mem_a, mem_d
  );
endinterface

// File: rtl/ej32_store_seq.sv
// Byte-serial store sequencer: emits a 1/2/4-byte TOS value to the 8-bit memory bus,
// most significant byte first, at consecutive (wrapping) byte addresses.
module ej32_store_seq #(
  parameter int DSZ = 32,
  parameter int ASZ = 17
) (
  input  logic              clk,
  input  logic              rst,
  ej32_store_seq_if.slave   io_st
);

  typedef enum logic {IDLE, WR} state_t;

  state_t         r_state;
  logic [DSZ-1:0] r_sreg;
  logic [ASZ-1:0] r_addr;
  logic [2:0]     r_cnt;
  logic           r_done;
  logic           r_err;

  state_t         w_next;
  logic [DSZ-1:0] w_sreg;
  logic [ASZ-1:0] w_addr;
  logic [2:0]     w_cnt;
  logic           w_done;
  logic           w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sreg  <= w_sreg;
      r_addr  <= w_addr;
      r_cnt   <= w_cnt;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  // The value is left-aligned on accept so every byte is taken from the top of the shift register.
  always_comb begin
    w_next = r_state;
    w_sreg = r_sreg;
    w_addr = r_addr;
    w_cnt  = r_cnt;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_st.st_req) begin
          case (io_st.st_wsz)
            2'd0: begin
              w_sreg = io_st.st_d << (DSZ - 8);
              w_cnt  = 3'd1;
              w_addr = io_st.st_a;
              w_next = WR;
            end
            2'd1: begin
              w_sreg = io_st.st_d << (DSZ - 16);
              w_cnt  = 3'd2;
              w_addr = io_st.st_a;
              w_next = WR;
            end
            2'd2: begin
              w_sreg = io_st.st_d << (DSZ - 32);
              w_cnt  = 3'd4;
              w_addr = io_st.st_a;
              w_next = WR;
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      WR: begin
        if (io_st.mem_gnt) begin
          w_sreg = r_sreg << 8;
          w_addr = r_addr + 1'b1;
          w_cnt  = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign io_st.st_rdy  = (r_state == IDLE);
  assign io_st.mem_we  = (r_state == WR);
  assign io_st.mem_a   = r_addr;
  assign io_st.mem_d   = r_sreg[DSZ-1 -: 8];
  assign io_st.st_done = r_done;
  assign io_st.st_err  = r_err;

endmodule

// File: tb/tb_ej32_store_seq.sv
// Directed self-checking bench for ej32_store_seq; outputs are sampled on the falling edge.
module tb_ej32_store_seq;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  ej32_store_seq_if #(.DSZ(32), .ASZ(17)) sif ();

  ej32_store_seq #(.DSZ(32), .ASZ(17)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_st (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBus(input string tag, input logic we, input logic [16:0] a,
                          input logic [7:0] d, input logic rdy, input logic done);
    checkOutput({tag, ".we"},   32'(sif.mem_we),  32'(we));
    if (we) begin
      checkOutput({tag, ".a"},  32'(sif.mem_a),   32'(a));
      checkOutput({tag, ".d"},  32'(sif.mem_d),   32'(d));
    end
    checkOutput({tag, ".rdy"},  32'(sif.st_rdy),  32'(rdy));
    checkOutput({tag, ".done"}, 32'(sif.st_done), 32'(done));
    checkOutput({tag, ".err"},  32'(sif.st_err),  32'd0);
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] wsz, input logic [16:0] a,
                               input logic [31:0] d, input logic gnt);
    sif.st_req  = req;
    sif.st_wsz  = wsz;
    sif.st_a    = a;
    sif.st_d    = d;
    sif.mem_gnt = gnt;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  expInt [4];
    logic [7:0]  expB2b [4];
    logic [16:0] a;
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 17'h0, 32'h0, 1'b0);

    @(negedge clk);
    checkBus("reset", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);
    checkOutput("reset.a", 32'(sif.mem_a), 32'h0);
    checkOutput("reset.d", 32'(sif.mem_d), 32'h0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] int store, mem_gnt held high");
    expInt = '{8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus(1'b1, 2'd2, 17'h00100, 32'h12345678, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      sif.st_req = 1'b0;
      a = 17'h00100 + 17'(i);
      checkBus($sformatf("int.b%0d", i), 1'b1, a, expInt[i], 1'b0, 1'b0);
    end
    stepCycle();
    checkBus("int.done", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);

    $display("[TB] short store with address wrap");
    applyStimulus(1'b1, 2'd1, 17'h1FFFF, 32'hDEADBEEF, 1'b1);
    stepCycle();
    sif.st_req = 1'b0;
    checkBus("short.b0", 1'b1, 17'h1FFFF, 8'hBE, 1'b0, 1'b0);
    stepCycle();
    checkBus("short.b1", 1'b1, 17'h00000, 8'hEF, 1'b0, 1'b0);
    stepCycle();
    checkBus("short.done", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);
    stepCycle();
    checkBus("short.after", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);

    $display("[TB] byte store with 3-cycle stall");
    applyStimulus(1'b1, 2'd0, 17'h00042, 32'hAABBCCDD, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      stepCycle();
      sif.st_req = 1'b0;
      checkBus($sformatf("stall.c%0d", k), 1'b1, 17'h00042, 8'hDD, 1'b0, 1'b0);
      if (k == 4) sif.mem_gnt = 1'b1;
    end
    stepCycle();
    checkBus("stall.done", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);

    $display("[TB] reserved width");
    applyStimulus(1'b1, 2'd3, 17'h00055, 32'h01020304, 1'b1);
    stepCycle();
    sif.st_req = 1'b0;
    checkOutput("err.pulse", 32'(sif.st_err), 32'd1);
    checkOutput("err.we", 32'(sif.mem_we), 32'd0);
    checkOutput("err.rdy", 32'(sif.st_rdy), 32'd1);
    checkOutput("err.done", 32'(sif.st_done), 32'd0);
    stepCycle();
    checkBus("err.after", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);

    $display("[TB] request during WR is ignored");
    applyStimulus(1'b1, 2'd1, 17'h00020, 32'h0000A1B2, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 2'd2, 17'h00700, 32'h99887766, 1'b1);
    checkBus("busy.b0", 1'b1, 17'h00020, 8'hA1, 1'b0, 1'b0);
    stepCycle();
    checkBus("busy.b1", 1'b1, 17'h00021, 8'hB2, 1'b0, 1'b0);
    sif.st_req = 1'b0;
    stepCycle();
    checkBus("busy.done", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);
    stepCycle();
    checkBus("busy.after", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-store");
    applyStimulus(1'b1, 2'd2, 17'h00400, 32'h0BADF00D, 1'b1);
    stepCycle();
    sif.st_req = 1'b0;
    checkBus("abort.b0", 1'b1, 17'h00400, 8'h0B, 1'b0, 1'b0);
    stepCycle();
    checkBus("abort.b1", 1'b1, 17'h00401, 8'hAD, 1'b0, 1'b0);
    stepCycle();
    checkBus("abort.b2", 1'b1, 17'h00402, 8'hF0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkBus("abort.rst", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);
    checkOutput("abort.a", 32'(sif.mem_a), 32'h0);
    stepCycle();
    checkBus("abort.hold", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);
    rst = 1'b0;
    stepCycle();
    checkBus("abort.nodone", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 17'h00010, 32'h000000A5, 1'b1);
    stepCycle();
    sif.st_req = 1'b0;
    checkBus("post.b0", 1'b1, 17'h00010, 8'hA5, 1'b0, 1'b0);
    stepCycle();
    checkBus("post.done", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);

    $display("[TB] back-to-back stores");
    expB2b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    applyStimulus(1'b1, 2'd2, 17'h00200, 32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      sif.st_req = 1'b0;
      a = 17'h00200 + 17'(i);
      checkBus($sformatf("b2b.b%0d", i), 1'b1, a, expB2b[i], 1'b0, 1'b0);
    end
    stepCycle();
    checkBus("b2b.done1", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'd0, 17'h00300, 32'h11223344, 1'b1);
    stepCycle();
    sif.st_req = 1'b0;
    checkBus("b2b.second", 1'b1, 17'h00300, 8'h44, 1'b0, 1'b0);
    stepCycle();
    checkBus("b2b.done2", 1'b0, 17'h0, 8'h0, 1'b1, 1'b1);
    stepCycle();
    checkBus("b2b.idle", 1'b0, 17'h0, 8'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/ej32_store_seq.md
Name: ej32_store_seq

Overview:
- Byte-serial memory store sequencer for the eJ32 core.
- It is the write-direction counterpart of the arithmetic unit's byte-wise load/merge path. The AU assembles TOS from successive memory bytes MSB-first; this block takes a TOS value plus an address and emits it to the 8-bit memory bus as 1, 2 or 4 big-endian bytes.
- Serves bastore/sastore/iastore and the eForth put path.
- Handshakes with the control FSM on the request side and with the memory arbiter on the bus side.

Parameters:
- DSZ, 32, data width of the stored value (multiple of 8, >= 32).
- ASZ, 17, memory byte-address width.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset, asynchronous, active-high.
- st_req  input  1  store request, qualified by st_rdy.
- st_rdy  output  1  sequencer idle; can accept a request.
- st_wsz  input  2  store width: 0=byte, 1=short, 2=int, 3=reserved.
- st_a  input  ASZ  base byte address.
- st_d  input  DSZ  value to store (TOS).
- st_done  output  1  one-cycle pulse when the last byte has been accepted by memory.
- st_err  output  1  one-cycle pulse when a request had st_wsz=3.
- mem_we  output  1  byte write request to memory bus.
- mem_a  output  ASZ  byte address of the current write.
- mem_d  output  8  byte data of the current write.
- mem_gnt  input  1  memory accepts the current byte this cycle.

Behaviour:
- Reset (async, immediate):
  - State=IDLE, st_rdy=1, st_done=0, st_err=0, mem_we=0, mem_a=0, mem_d=0.
  - Internal shift register and byte counter are cleared.
  - Reset mid-store abandons the remaining bytes; no st_done is issued.
- States: IDLE, WR.
- IDLE:
  - st_rdy=1. A request is accepted on a clk edge with st_req=1.
  - wsz 0/1/2: latch n=1/2/4, shift reg = st_d << (DSZ - 8n) (value left-aligned, MSB first), addr = st_a. Next state WR.
  - wsz 3: no bus activity; st_err=1 for exactly the next cycle; stay IDLE.
- WR:
  - st_rdy=0. mem_we=1, mem_a=addr, mem_d = shift reg [DSZ-1:DSZ-8].
  - All outputs are registered. mem_we rises in the cycle after acceptance.
  - On an edge with mem_gnt=1: shift reg <<= 8, addr += 1 (mod 2^ASZ, wraps 2^ASZ-1 -> 0), count -= 1.
  - If that was the last byte: mem_we=0, st_done=1 for one cycle, state IDLE.
  - mem_gnt=0 holds mem_we/mem_a/mem_d stable (stall of any length).
  - st_req while in WR is ignored; no queueing.
- Byte order: big-endian.
  - Short: mem[a]=st_d[15:8], mem[a+1]=st_d[7:0].
  - Int: mem[a]=st_d[31:24] .. mem[a+3]=st_d[7:0].
  - Byte: mem[a]=st_d[7:0].
  - Bits above the stored width are ignored.
- Latency with mem_gnt held 1, accept at edge 0:
  - Bytes are written in cycles 1..n.
  - st_done is high in cycle n+1, which is also the first IDLE cycle. st_rdy=1 there, so a new request can be accepted at the end of cycle n+1.
- Simultaneous: st_done and a new acceptance in the same cycle is legal; st_done refers to the previous store.
- st_done and st_err are never high together.
- mem_we never drops before its byte is granted.

Test Plan:
- Reset, then int store st_a=0x00100, st_d=0x12345678, mem_gnt=1 -> writes 0x12@0x100, 0x34@0x101, 0x56@0x102, 0x78@0x103 in cycles 1-4; st_done in cycle 5; st_rdy low in cycles 1-4.
- Short store st_a=0x1FFFF (ASZ=17), st_d=0xDEADBEEF -> 0xBE@0x1FFFF, 0xEF@0x00000 (address wrap); exactly 2 writes, then st_done.
- Byte store st_d=0xAABBCCDD with mem_gnt low for 3 cycles then high -> mem_we/mem_a/mem_d held stable for 4 cycles, single write 0xDD, st_done the cycle after grant.
- st_wsz=3 -> st_err pulse for 1 cycle, mem_we stays 0, st_rdy stays 1; st_req during WR is ignored and produces no extra bytes.
- Assert rst asynchronously after the 2nd byte of an int store -> mem_we=0 immediately, no st_done; a following byte store behaves normally.
- Back-to-back: int store accepted, second byte store accepted in the st_done cycle -> st_done for the first store, then 1 write for the second, its own st_done.
